// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and encodings for the multicycle RV32I control path.
// FSM state enum, opcodes, ALU operation codes and datapath mux encodings.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_JALR1,
        S_JALR2,
        S_LUI,
        S_AUIPC,
        S_BRANCH,
        S_ILLEGAL
    } state_t;

    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_R,
        CLS_I,
        CLS_BR
    } alu_class_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_GEU  = 4'b1001;
    localparam logic [3:0] ALU_SLLI = 4'b1010;
    localparam logic [3:0] ALU_SRLI = 4'b1011;
    localparam logic [3:0] ALU_SRAI = 4'b1100;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_GE   = 4'b1110;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        logic [2:0] r;
        case (op)
            OP_STORE:         r = IMM_S;
            OP_BRANCH:        r = IMM_B;
            OP_LUI, OP_AUIPC: r = IMM_U;
            OP_JAL:           r = IMM_J;
            default:          r = IMM_I;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps operation class, funct3 and funct7[5] to the ALU code.
// Branch compares reuse the ALU; their codes are picked so Zero decides taken.
module alu_decoder
    import cpu_pkg::*;
(
    input  alu_class_t op_class,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_ctrl
);

    // Operation-class and funct3 lookup
    always_comb begin
        alu_ctrl = ALU_ADD;
        unique case (op_class)
            CLS_ADD: alu_ctrl = ALU_ADD;
            CLS_R: begin
                unique case (funct3)
                    3'b000: alu_ctrl = funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b001: alu_ctrl = ALU_SLL;
                    3'b010: alu_ctrl = ALU_SLT;
                    3'b011: alu_ctrl = ALU_SLTU;
                    3'b100: alu_ctrl = ALU_XOR;
                    3'b101: alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_ctrl = ALU_OR;
                    3'b111: alu_ctrl = ALU_AND;
                endcase
            end
            CLS_I: begin
                unique case (funct3)
                    3'b000: alu_ctrl = ALU_ADD;
                    3'b001: alu_ctrl = ALU_SLLI;
                    3'b010: alu_ctrl = ALU_SLT;
                    3'b011: alu_ctrl = ALU_SLTU;
                    3'b100: alu_ctrl = ALU_XOR;
                    3'b101: alu_ctrl = funct7_5 ? ALU_SRAI : ALU_SRLI;
                    3'b110: alu_ctrl = ALU_OR;
                    3'b111: alu_ctrl = ALU_AND;
                endcase
            end
            CLS_BR: begin
                unique case (funct3)
                    3'b000:  alu_ctrl = ALU_SUB;
                    3'b001:  alu_ctrl = ALU_SUB;
                    3'b100:  alu_ctrl = ALU_SLT;
                    3'b101:  alu_ctrl = ALU_GE;
                    3'b110:  alu_ctrl = ALU_SLTU;
                    3'b111:  alu_ctrl = ALU_GEU;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: instruction sequencer for the multicycle RV32I core.
// Optional CTRL_ILLEGAL_TRAP_EN makes ILLEGAL a terminal trap with IllegalInstr.
module multicycle_control_fsm
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUControlSignal,
    output logic [2:0]  ImmSrc
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic        IllegalInstr
`endif
);

    state_t     state;
    state_t     state_next;
    alu_class_t alu_class;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       unused_instr;

    assign opcode       = Instr[6:0];
    assign funct3       = Instr[14:12];
    assign funct7_5     = Instr[30];
    assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Next-state logic and per-state datapath controls
    always_comb begin
        state_next = state;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        alu_class  = CLS_ADD;
        unique case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                if (MemReady) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECR;
                    OP_I:              state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR1;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    OP_FENCE:          state_next = S_FETCH;
                    default:           state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                AdrSrc   = 1'b1;
                if (MemReady) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_MEM;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                AdrSrc    = 1'b1;
                if (MemReady) state_next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RD1;
                alu_class  = CLS_R;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                alu_class  = CLS_I;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL, S_JALR2: begin
                pc_write   = 1'b1;
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                state_next = S_ALUWB;
            end
            S_JALR1: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                state_next = S_JALR2;
            end
            S_LUI: begin
                ALUSrcA    = SRCA_ZERO;
                ALUSrcB    = SRCB_IMM;
                state_next = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_IMM;
                state_next = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_RD1;
                alu_class = CLS_BR;
                if (funct3[2:1] == 2'b01) begin
                    state_next = S_ILLEGAL;
                end else begin
                    pc_write   = (funct3 == 3'b000) ? Zero : ~Zero;
                    state_next = S_FETCH;
                end
            end
            S_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                state_next = S_ILLEGAL;
`else
                state_next = S_FETCH;
`endif
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .op_class (alu_class),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_ctrl (ALUControlSignal)
    );

    assign PCWrite  = pc_write & ~reset;
    assign IRWrite  = ir_write & ~reset;
    assign MemRead  = mem_read & ~reset;
    assign MemWrite = mem_write & ~reset;
    assign RegWrite = reg_write & ~reset;
    assign ImmSrc   = imm_src(opcode);

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign IllegalInstr = (state == S_ILLEGAL);
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomised scoreboard bench for multicycle_control_fsm.
// The driver pushes per-cycle expected controls; a negedge monitor compares.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic        Zero;
    logic        MemReady;
    logic        PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [3:0]  ALUControlSignal;
    logic [2:0]  ImmSrc;
    logic        ill_out;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic        IllegalInstr;
    assign ill_out = IllegalInstr;
`else
    assign ill_out = 1'b0;
`endif

    multicycle_control_fsm dut (
        .clk              (clk),
        .reset            (reset),
        .Instr            (Instr),
        .Zero             (Zero),
        .MemReady         (MemReady),
        .PCWrite          (PCWrite),
        .IRWrite          (IRWrite),
        .AdrSrc           (AdrSrc),
        .MemRead          (MemRead),
        .MemWrite         (MemWrite),
        .RegWrite         (RegWrite),
        .ResultSrc        (ResultSrc),
        .ALUSrcA          (ALUSrcA),
        .ALUSrcB          (ALUSrcB),
        .ALUControlSignal (ALUControlSignal),
        .ImmSrc           (ImmSrc)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .IllegalInstr     (IllegalInstr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] vec;
        logic        ill;
        int          id;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    int          step_id  = 0;
    logic [18:0] got;

    // {PCWrite,IRWrite,AdrSrc,MemRead,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALU,ImmSrc}
    assign got = {PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUControlSignal, ImmSrc};

    // Monitor: one expected control word per clock
    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (got !== mon_e.vec || ill_out !== mon_e.ill) begin
                failures++;
                $display("FAIL ctrl step %0d: got %b ill=%b, expected %b ill=%b",
                         mon_e.id, got, ill_out, mon_e.vec, mon_e.ill);
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // enables order: PCWrite IRWrite AdrSrc MemRead MemWrite RegWrite
    function automatic logic [18:0] pk(input logic [5:0] en, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [3:0] alu, input logic [2:0] im);
        return {en, rs, sa, sb, alu, im};
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        if (op == 7'b0100011) return 3'b001;
        if (op == 7'b1100011) return 3'b010;
        if (op == 7'b0110111 || op == 7'b0010111) return 3'b011;
        if (op == 7'b1101111) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic [3:0] rcode(input logic [2:0] f3, input logic f7);
        logic [3:0] t [8] = '{4'd0, 4'd5, 4'd13, 4'd8, 4'd4, 4'd6, 4'd3, 4'd2};
        if (f7 && f3 == 3'd0) return 4'd1;
        if (f7 && f3 == 3'd5) return 4'd7;
        return t[f3];
    endfunction

    function automatic logic [3:0] icode(input logic [2:0] f3, input logic f7);
        logic [3:0] t [8] = '{4'd0, 4'd10, 4'd13, 4'd8, 4'd4, 4'd11, 4'd3, 4'd2};
        if (f7 && f3 == 3'd5) return 4'd12;
        return t[f3];
    endfunction

    function automatic logic [3:0] bcode(input logic [2:0] f3);
        logic [3:0] t [8] = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd13, 4'd14, 4'd8, 4'd9};
        return t[f3];
    endfunction

    task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", nm, g, e);
        end
    endtask

    // ResultSrc is not constrained while reset is held
    task automatic chk_rst(input string nm, input logic [2:0] im);
        chk(nm, {12'd0, ill_out, got[18:13], got[10:0]},
                {12'd0, 1'b0, 6'd0, 2'b00, 2'b10, 4'd0, im});
    endtask

    task automatic cyc(input logic [31:0] ins, input logic mr, input logic z,
                       input logic [18:0] v, input logic ill);
        exp_t e;
        Instr    = ins;
        MemReady = mr;
        Zero     = z;
        e.vec    = v;
        e.ill    = ill;
        e.id     = step_id++;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic ill_tail(input logic [31:0] ins, input logic [2:0] im);
`ifdef CTRL_ILLEGAL_TRAP_EN
        repeat (4) cyc(ins, rb(), rb(), pk(6'b0, 2'b00, 2'b00, 2'b00, 4'd0, im), 1'b1);
`else
        cyc(ins, rb(), rb(), pk(6'b0, 2'b00, 2'b00, 2'b00, 4'd0, im), 1'b0);
`endif
    endtask

    // Reference behaviour of one whole instruction, cycle by cycle
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input int zb);
        logic [6:0]  op = ins[6:0];
        logic [2:0]  f3 = ins[14:12];
        logic        f7 = ins[30];
        logic [2:0]  im = imm_of(ins[6:0]);
        int          nf = (fw < 0) ? int'($urandom_range(0, 2)) : fw;
        int          nm = (mw < 0) ? int'($urandom_range(0, 2)) : mw;
        logic        z  = (zb < 0) ? rb() : zb[0];
        logic [18:0] fe = pk(6'b000100, 2'b10, 2'b00, 2'b10, 4'd0, im);
        logic [18:0] wb = pk(6'b000001, 2'b00, 2'b00, 2'b00, 4'd0, im);
        logic [18:0] ad = pk(6'b000000, 2'b00, 2'b10, 2'b01, 4'd0, im);
        logic [18:0] jl = pk(6'b100000, 2'b00, 2'b01, 2'b10, 4'd0, im);
        logic [18:0] mr = pk(6'b001100, 2'b00, 2'b00, 2'b00, 4'd0, im);
        logic [18:0] mx = pk(6'b001010, 2'b00, 2'b00, 2'b00, 4'd0, im);
        logic        tk;
        repeat (nf) cyc(ins, 1'b0, rb(), fe, 1'b0);
        cyc(ins, 1'b1, rb(), pk(6'b110100, 2'b10, 2'b00, 2'b10, 4'd0, im), 1'b0);
        cyc(ins, rb(), rb(), pk(6'b0, 2'b00, 2'b01, 2'b01, 4'd0, im), 1'b0);
        case (op)
            7'b0000011: begin
                cyc(ins, rb(), rb(), ad, 1'b0);
                repeat (nm) cyc(ins, 1'b0, rb(), mr, 1'b0);
                cyc(ins, 1'b1, rb(), mr, 1'b0);
                cyc(ins, rb(), rb(), pk(6'b000001, 2'b01, 2'b00, 2'b00, 4'd0, im), 1'b0);
            end
            7'b0100011: begin
                cyc(ins, rb(), rb(), ad, 1'b0);
                repeat (nm) cyc(ins, 1'b0, rb(), mx, 1'b0);
                cyc(ins, 1'b1, rb(), mx, 1'b0);
            end
            7'b0110011: begin
                cyc(ins, rb(), rb(), pk(6'b0, 2'b00, 2'b10, 2'b00, rcode(f3, f7), im), 1'b0);
                cyc(ins, rb(), rb(), wb, 1'b0);
            end
            7'b0010011: begin
                cyc(ins, rb(), rb(), pk(6'b0, 2'b00, 2'b10, 2'b01, icode(f3, f7), im), 1'b0);
                cyc(ins, rb(), rb(), wb, 1'b0);
            end
            7'b1100011: begin
                if (f3 == 3'b010 || f3 == 3'b011) begin
                    cyc(ins, rb(), z, pk(6'b0, 2'b00, 2'b10, 2'b00, 4'd0, im), 1'b0);
                    ill_tail(ins, im);
                end else begin
                    tk = (f3 == 3'b000) ? z : !z;
                    cyc(ins, rb(), z, pk({tk, 5'b0}, 2'b00, 2'b10, 2'b00, bcode(f3), im), 1'b0);
                end
            end
            7'b1101111: begin
                cyc(ins, rb(), rb(), jl, 1'b0);
                cyc(ins, rb(), rb(), wb, 1'b0);
            end
            7'b1100111: begin
                cyc(ins, rb(), rb(), ad, 1'b0);
                cyc(ins, rb(), rb(), jl, 1'b0);
                cyc(ins, rb(), rb(), wb, 1'b0);
            end
            7'b0110111: begin
                cyc(ins, rb(), rb(), pk(6'b0, 2'b00, 2'b11, 2'b01, 4'd0, im), 1'b0);
                cyc(ins, rb(), rb(), wb, 1'b0);
            end
            7'b0010111: begin
                cyc(ins, rb(), rb(), pk(6'b0, 2'b00, 2'b01, 2'b01, 4'd0, im), 1'b0);
                cyc(ins, rb(), rb(), wb, 1'b0);
            end
            7'b0001111: ;
            default: ill_tail(ins, im);
        endcase
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [12] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                  7'b0010111, 7'b0001111, 7'b1110011, 7'b0000000};
        logic [31:0] r = $urandom;
`ifdef CTRL_ILLEGAL_TRAP_EN
        int          n = 10;
`else
        int          n = 12;
`endif
        r[6:0] = ops[$urandom_range(0, n - 1)];
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (r[6:0] == 7'b1100011 && r[14:13] == 2'b01) r[14] = 1'b1;
`endif
        return r;
    endfunction

    // Store interrupted by reset while waiting in MEMWRITE
    task automatic reset_mid_store(input logic [31:0] ins);
        exp_t e;
        cyc(ins, 1'b1, rb(), pk(6'b110100, 2'b10, 2'b00, 2'b10, 4'd0, 3'b001), 1'b0);
        cyc(ins, rb(), rb(), pk(6'b0, 2'b00, 2'b01, 2'b01, 4'd0, 3'b001), 1'b0);
        cyc(ins, rb(), rb(), pk(6'b0, 2'b00, 2'b10, 2'b01, 4'd0, 3'b001), 1'b0);
        Instr    = ins;
        MemReady = 1'b0;
        e.vec    = pk(6'b001010, 2'b00, 2'b00, 2'b00, 4'd0, 3'b001);
        e.ill    = 1'b0;
        e.id     = step_id++;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_memwrite_drop", {31'd0, MemWrite}, 32'd0);
        chk_rst("rst_mid_outputs", 3'b001);
        @(posedge clk);
        #1;
        chk_rst("rst_mid_hold", 3'b001);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        Instr    = 32'h0000_0023;
        MemReady = 1'b0;
        Zero     = 1'b0;
        #3;
        chk_rst("reset_state", 3'b001);
        repeat (2) @(posedge clk);
        #1;
        chk_rst("reset_hold", 3'b001);
        reset = 1'b0;

        run_instr(32'h0020_81b3, 0, 0, -1);  // add x3,x1,x2
        run_instr(32'h4020_81b3, 0, 0, -1);  // sub x3,x1,x2
        run_instr(32'h4033_5293, 0, 0, -1);  // srai x5,x6,3
        run_instr(32'h0020_9463, 0, 0, 1);   // bne, Zero=1
        run_instr(32'h0020_9463, 0, 0, 0);   // bne, Zero=0
        run_instr(32'h0020_a283, 0, 2, -1);  // lw, two wait cycles
        run_instr(32'h0000_000f, 0, 0, -1);  // fence
        reset_mid_store(32'h0020_a023);      // sw
        run_instr(32'h0000_0037, 1, 0, -1);  // lui after reset

        repeat (300) run_instr(rand_instr(), -1, -1, -1);

        run_instr(32'h0000_0073, 0, 0, -1);  // ecall: unsupported

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
